// File: rtl/kgp_io_input_port_if.sv
// Handshake/bus bundle for kgp_io_input_port: raw board inputs, processor read strobe and read-side outputs.
// Optional press_cnt member is present only when KGP_IO_PRESS_COUNT_EN is defined.
interface kgp_io_input_port_if #(
    parameter int unsigned DATA_W = 16
);
    logic              button;
    logic [DATA_W-1:0] sw;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              data_valid;
    logic              overrun;
`ifdef KGP_IO_PRESS_COUNT_EN
    logic [7:0]        press_cnt;

    modport master (output button, sw, rd_en, input rd_data, data_valid, overrun, press_cnt);
    modport slave  (input button, sw, rd_en, output rd_data, data_valid, overrun, press_cnt);
`else
    modport master (output button, sw, rd_en, input rd_data, data_valid, overrun);
    modport slave  (input button, sw, rd_en, output rd_data, data_valid, overrun);
`endif
endinterface

// File: rtl/kgp_io_input_port.sv
// KGP miniRISC input port: synchronised, debounced push button snapshots the switch bank for a strobed read.
// Define KGP_IO_PRESS_COUNT_EN to add the 8-bit wrapping press_cnt output.
module kgp_io_input_port #(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 20
) (
    input logic                clk,
    input logic                rst,
    kgp_io_input_port_if.slave io
);
    typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              btn_m_q, btn_s_q;
    logic [DATA_W-1:0] sw_m_q, sw_s_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              capture;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              data_valid_q, data_valid_d;
    logic              overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m_q <= 1'b0;
            btn_s_q <= 1'b0;
            sw_m_q  <= '0;
            sw_s_q  <= '0;
        end else begin
            btn_m_q <= io.button;
            btn_s_q <= btn_m_q;
            sw_m_q  <= io.sw;
            sw_s_q  <= sw_m_q;
        end
    end

    // capture is decoded from current state so it lands on the ARM->HELD edge itself
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s_q) state_d = ARM;
            end
            ARM: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    capture = 1'b1;
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!btn_s_q) state_d = DISARM;
            end
            DISARM: begin
                if (btn_s_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A capture coinciding with rd_en treats the old sample as consumed
    always_comb begin
        rd_data_d    = rd_data_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        if (capture) begin
            rd_data_d    = sw_s_q;
            data_valid_d = 1'b1;
            if (data_valid_q) overrun_d = !io.rd_en;
        end else if (io.rd_en && data_valid_q) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_data_q    <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_data_q    <= rd_data_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign io.rd_data    = rd_data_q;
    assign io.data_valid = data_valid_q;
    assign io.overrun    = overrun_q;

`ifdef KGP_IO_PRESS_COUNT_EN
    logic [7:0] press_cnt_q, press_cnt_d;

    always_comb begin
        press_cnt_d = press_cnt_q;
        if (capture) press_cnt_d = press_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) press_cnt_q <= '0;
        else     press_cnt_q <= press_cnt_d;
    end

    assign io.press_cnt = press_cnt_q;
`endif
endmodule

// File: tb/tb_kgp_io_input_port.sv
// Bench for kgp_io_input_port: press table plus hand sequences, with a capture scoreboard.
// Press-counter checks compile in when KGP_IO_PRESS_COUNT_EN is defined.
module tb_kgp_io_input_port;
    logic clk = 1'b0;
    logic rst = 1'b1;

    kgp_io_input_port_if #(.DATA_W(16)) io ();

    kgp_io_input_port #(
        .DATA_W(16),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(io)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] cap_q[$];
    bit          mon_en = 1'b1;
    logic [7:0]  exp_press = 8'd0;

    typedef struct {
        logic [15:0] sw;
        int unsigned hold;
        bit          rd;
        logic [15:0] exp_data;
        bit          exp_dv;
        bit          exp_ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: any new data_valid rise or rd_data change outside reset is a capture
    logic        dv_prev = 1'b0;
    logic [15:0] rd_prev = '0;
    always @(negedge clk) begin
        if (!rst && mon_en && ((io.data_valid && !dv_prev) || (io.rd_data !== rd_prev))) begin
            if (cap_q.size() == 0) begin
                chk("spurious_capture", {16'h0, io.rd_data}, 32'hDEAD_0000);
            end else begin
                logic [15:0] e;
                e = cap_q.pop_front();
                chk("sb_capture", {16'h0, io.rd_data}, {16'h0, e});
            end
        end
        dv_prev = io.data_valid;
        rd_prev = io.rd_data;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_capture(input logic [15:0] v);
        cap_q.push_back(v);
        exp_press = exp_press + 8'd1;
    endtask

    task automatic pulse_rd();
        io.rd_en = 1'b1;
        @(negedge clk);
        io.rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [15:0] v, input int unsigned hold);
        io.sw = v;
        io.button = (hold != 0);
        repeat (hold) @(negedge clk);
        io.button = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic [15:0] d, input bit dv, input bit ov);
        chk({name, "_data"}, {16'h0, io.rd_data}, {16'h0, d});
        chk({name, "_dv"}, {31'h0, io.data_valid}, {31'h0, dv});
        chk({name, "_ov"}, {31'h0, io.overrun}, {31'h0, ov});
    endtask

    initial begin
        // capture needs raw button high on DEBOUNCE_CYCLES+1 = 5 consecutive edges
        vecs[0] = '{16'h5A5A, 20, 1'b0, 16'h5A5A, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF,  3, 1'b0, 16'h5A5A, 1'b1, 1'b0};
        vecs[2] = '{16'h1111,  4, 1'b0, 16'h5A5A, 1'b1, 1'b0};
        vecs[3] = '{16'h1111,  0, 1'b1, 16'h5A5A, 1'b0, 1'b0};
        vecs[4] = '{16'h1111,  0, 1'b1, 16'h5A5A, 1'b0, 1'b0};
        vecs[5] = '{16'h1234,  5, 1'b0, 16'h1234, 1'b1, 1'b0};
        vecs[6] = '{16'h1234,  0, 1'b1, 16'h1234, 1'b0, 1'b0};
        vecs[7] = '{16'h0001, 10, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[8] = '{16'h0002, 10, 1'b0, 16'h0002, 1'b1, 1'b1};
        vecs[9] = '{16'h0002,  0, 1'b1, 16'h0002, 1'b0, 1'b0};

        io.button = 1'b1;
        io.sw     = 16'hFFFF;
        io.rd_en  = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("reset", 16'h0000, 1'b0, 1'b0);
        io.button = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // latency: first sampled high at edge 0, capture on edge 6
        io.sw = 16'h00A5;
        io.button = 1'b1;
        expect_capture(16'h00A5);
        repeat (6) @(negedge clk);
        chk("lat_dv_before", {31'h0, io.data_valid}, 32'h0);
        @(negedge clk);
        chk_out("lat_edge6", 16'h00A5, 1'b1, 1'b0);
        repeat (14) @(negedge clk);
        io.button = 1'b0;
        repeat (14) @(negedge clk);
        pulse_rd();
        chk_out("lat_read", 16'h00A5, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].hold >= 5) expect_capture(vecs[i].sw);
            press(vecs[i].sw, vecs[i].hold);
            if (vecs[i].rd) pulse_rd();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_dv, vecs[i].exp_ov);
        end

        // release bounce while HELD must not recapture
        io.sw = 16'h0C0C;
        io.button = 1'b1;
        expect_capture(16'h0C0C);
        repeat (10) @(negedge clk);
        pulse_rd();
        io.button = 1'b0;
        repeat (2) @(negedge clk);
        io.button = 1'b1;
        repeat (6) @(negedge clk);
        io.button = 1'b0;
        repeat (14) @(negedge clk);
        chk_out("bounce", 16'h0C0C, 1'b0, 1'b0);

        // read strobe on the capture edge with a sample pending
        expect_capture(16'h0111);
        press(16'h0111, 10);
        io.sw = 16'h0BEE;
        io.button = 1'b1;
        expect_capture(16'h0BEE);
        repeat (6) @(negedge clk);
        io.rd_en = 1'b1;
        @(negedge clk);
        io.rd_en = 1'b0;
        chk_out("simul", 16'h0BEE, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        io.button = 1'b0;
        repeat (14) @(negedge clk);
        pulse_rd();
        chk_out("simul_read", 16'h0BEE, 1'b0, 1'b0);

        // reset while held, then fresh single capture once reset lifts
        io.sw = 16'h0777;
        io.button = 1'b1;
        expect_capture(16'h0777);
        repeat (10) @(negedge clk);
        chk("mid_dv", {31'h0, io.data_valid}, 32'h1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_out("mid_reset", 16'h0000, 1'b0, 1'b0);
        exp_press = 8'd0;
        expect_capture(16'h0777);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk_out("post_reset", 16'h0777, 1'b1, 1'b0);
        io.button = 1'b0;
        repeat (14) @(negedge clk);
        pulse_rd();

`ifdef KGP_IO_PRESS_COUNT_EN
        chk("press_cnt", {24'h0, io.press_cnt}, {24'h0, exp_press});
        mon_en = 1'b0;
        press(16'h0000, 6);
        chk("press_cnt_inc", {24'h0, io.press_cnt}, {24'h0, exp_press + 8'd1});
        for (int i = 1; i < 256; i++) press(16'h0000, 6);
        pulse_rd();
        chk("press_cnt_wrap", {24'h0, io.press_cnt}, {24'h0, exp_press});
        mon_en = 1'b1;
`endif

        chk("sb_empty", cap_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/kgp_io_input_port.md
Name: kgp_io_input_port

Overview:
- Board-side input block for the KGP miniRISC.
- Synchronises and debounces a raw push button.
- On each debounced press, snapshots a synchronised switch bank into a read register and raises data_valid.
- The processor consumes the value with a one-cycle read strobe. This block is the input-direction counterpart of the processor's 16-bit output port.

Parameters:
- DATA_W, 16, width of the switch bank and of rd_data.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a press or a release. Minimum 2. Board builds override this to a large value.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- button  input  1  raw, asynchronous push button; high = pressed.
- sw  input  DATA_W  raw, asynchronous switch bank.
- rd_en  input  1  processor read strobe; one cycle consumes the pending sample.
- rd_data  output  DATA_W  last captured switch value (registered).
- data_valid  output  1  an unread sample is pending.
- overrun  output  1  sticky flag: a press was captured while an earlier sample was still unread.

Behaviour:
- Reset (rst=1 at an edge):
  - sync flops = 0
  - FSM = IDLE
  - counter = 0
  - rd_data = 0, data_valid = 0, overrun = 0
- Synchronisers: button and every sw bit each pass through two flops (btn_s, sw_s). Only btn_s and sw_s are used downstream.
- FSM states: IDLE, ARM, HELD, DISARM. The counter clears on every state change.
  - IDLE: btn_s=1 -> ARM.
  - ARM: btn_s=0 -> IDLE (glitch rejected, no capture). btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD with capture asserted on the same edge. Otherwise cnt++.
  - HELD: btn_s=0 -> DISARM. Never captures, so a held button yields exactly one capture.
  - DISARM: btn_s=1 -> HELD (bounce on release rejected). btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
- Latency: if the raw button is first sampled high at edge 0 and stays high, capture occurs at edge DEBOUNCE_CYCLES+2. rd_data and data_valid are visible after that edge.
- Capture: rd_data <= sw_s, data_valid <= 1.
- Read: rd_en=1 with data_valid=1 and no capture -> data_valid <= 0, overrun <= 0; rd_data holds its value.
- rd_en=1 with data_valid=0: no effect.
- Capture with data_valid=1 and rd_en=0: rd_data overwritten (newest wins), data_valid stays 1, overrun <= 1.
- Capture and rd_en on the same edge: the old sample counts as consumed. rd_data <= sw_s, data_valid = 1, overrun <= 0.
- overrun clears only on a consuming read or on reset.
- Reset mid-operation: all state returns to reset values. A button still held after rst deasserts is debounced afresh from IDLE and captured once.
- No combinational path from any input to any output.

Optional Feature:
- Macro: KGP_IO_PRESS_COUNT_EN
- Defined:
  - Adds output press_cnt [7:0], reset 0.
  - press_cnt increments by 1 on every capture edge, including overrun captures.
  - Wraps 255 -> 0; unaffected by rd_en.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Reset check: rst=1 for 2 cycles with button=1, sw=16'hFFFF -> rd_data=16'h0000, data_valid=0, overrun=0.
- Clean press: sw=16'h00A5; button first sampled high at edge 0 and held 20 cycles -> data_valid rises after edge 6 with rd_data=16'h00A5; exactly one capture.
- Glitch rejection: button high for 3 edges then low -> no capture; data_valid stays 0 and FSM returns to IDLE. Release bounce (low 2 cycles, then high) while HELD -> no second capture.
- Read handshake: after capturing 16'h1234, pulse rd_en one cycle -> data_valid=0 next cycle, rd_data still 16'h1234. A further rd_en has no effect.
- Overrun: capture 16'h0001, no read, then a second clean press with sw=16'h0002 -> rd_data=16'h0002, data_valid=1, overrun=1; one rd_en clears both flags.
- Simultaneous: rd_en asserted on the capture edge of 16'h0BEE while a sample is pending -> rd_data=16'h0BEE, data_valid=1, overrun=0. With KGP_IO_PRESS_COUNT_EN defined, 256 presses bring press_cnt back to 0.
